// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the RAM-side bus shared by the
// data-memory arbiter. The arbiter connects through the slave modport; the
// requesters and the RAM model connect through the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Port 0: CPU memory stage
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    // Port 1: loader / debug
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    // Single-port RAM bus
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_q,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_addr, ram_data, ram_wren,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_q,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_addr, ram_data, ram_wren,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data RAM.
// Port 0 is the CPU memory stage, port 1 the loader/debug port. Every output
// comes straight from a register, so no request reaches an output without
// passing through a flop. Reads take three cycles (IDLE, ISSUE, RDWAIT) to
// cover the RAM's one-cycle read latency; writes take two (IDLE, ISSUE).
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic              prio_r;     // port that wins a tie
    logic              winner_r;   // port owning the access in flight
    logic              is_write_r; // access in flight is a write

    logic              p0_gnt_r;
    logic              p1_gnt_r;
    logic              p0_rvalid_r;
    logic              p1_rvalid_r;
    logic [DATA_W-1:0] p0_rdata_r;
    logic [DATA_W-1:0] p1_rdata_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_data_r;
    logic              ram_wren_r;
    logic              busy_r;

    logic              any_req_s;
    logic              winner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Choose the winning port: a lone requester wins, a tie goes to prio_r.
    always_comb begin
        any_req_s = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            winner_s = prio_r;
        end else if (bus.p1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Route the winning port's command toward the RAM command registers.
    always_comb begin
        if (winner_s) begin
            sel_we_s    = bus.p1_we;
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
        end else begin
            sel_we_s    = bus.p0_we;
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
        end
    end

    // Sequencer FSM: arbitrates in IDLE, drives the RAM in ISSUE, and
    // captures read data in RDWAIT; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prio_r      <= 1'b0;
            winner_r    <= 1'b0;
            is_write_r  <= 1'b0;
            p0_gnt_r    <= 1'b0;
            p1_gnt_r    <= 1'b0;
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= {DATA_W{1'b0}};
            p1_rdata_r  <= {DATA_W{1'b0}};
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_data_r  <= {DATA_W{1'b0}};
            ram_wren_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // gnt and rvalid are single-cycle pulses
            p0_gnt_r    <= 1'b0;
            p1_gnt_r    <= 1'b0;
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        winner_r   <= winner_s;
                        is_write_r <= sel_we_s;
                        ram_addr_r <= sel_addr_s;
                        ram_data_r <= sel_wdata_s;
                        ram_wren_r <= sel_we_s;
                        prio_r     <= ~winner_s;
                        if (winner_s) begin
                            p1_gnt_r <= 1'b1;
                        end else begin
                            p0_gnt_r <= 1'b1;
                        end
                        busy_r  <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        ram_wren_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    ram_wren_r <= 1'b0;
                    if (is_write_r) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    // ram_q now reflects the address presented in ISSUE
                    if (winner_r) begin
                        p1_rdata_r  <= bus.ram_q;
                        p1_rvalid_r <= 1'b1;
                    end else begin
                        p0_rdata_r  <= bus.ram_q;
                        p0_rvalid_r <= 1'b1;
                    end
                    ram_wren_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ram_wren_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_gnt    = p0_gnt_r;
    assign bus.p1_gnt    = p1_gnt_r;
    assign bus.p0_rvalid = p0_rvalid_r;
    assign bus.p1_rvalid = p1_rvalid_r;
    assign bus.p0_rdata  = p0_rdata_r;
    assign bus.p1_rdata  = p1_rdata_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_data  = ram_data_r;
    assign bus.ram_wren  = ram_wren_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A transaction-level model predicts, per cycle,
// which grants, read returns and RAM commands must appear; a compare process
// checks the DUT against it every cycle. Directed scenarios add literal
// expectations, then randomized traffic with occasional resets follows.
module tb_dmem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int MAXC   = 8192;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    always #5 clk = ~clk;

    // cycle index; cycle c is the period following the c-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // single-port RAM with one-cycle read latency
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= ram[bus.ram_addr];
    end

    // requester state as driven by the bench
    bit                q_req   [2];
    logic              q_we    [2];
    logic [ADDR_W-1:0] q_addr  [2];
    logic [DATA_W-1:0] q_wdata [2];

    // model: expected events per cycle
    bit                e_gnt0 [MAXC];
    bit                e_gnt1 [MAXC];
    bit                e_rv0  [MAXC];
    bit                e_rv1  [MAXC];
    bit                e_wren [MAXC];
    bit                e_busy [MAXC];
    bit                e_cmd  [MAXC];
    bit                e_rst  [MAXC];
    logic [ADDR_W-1:0] e_addr [MAXC];
    logic [DATA_W-1:0] e_data [MAXC];
    logic [DATA_W-1:0] e_rd   [MAXC];
    logic [DATA_W-1:0] mem_m  [256];
    int                free_at = 0;
    bit                m_prio = 1'b0;

    bit                chk_en = 1'b0;
    int                cc;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_rd0;
    logic [DATA_W-1:0] h_rd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_port(input int k, input bit req, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        q_req[k] = req; q_we[k] = we; q_addr[k] = a; q_wdata[k] = d;
        if (k == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    // Model of one cycle's inputs: the arbiter is free from free_at on; an
    // access granted after cycle c occupies 2 (write) or 3 (read) cycles.
    task automatic model_step(input int c);
        bit w;
        if (rst) begin
            for (int i = c + 1; i <= c + 4; i++) begin
                e_gnt0[i] = 1'b0; e_gnt1[i] = 1'b0; e_rv0[i] = 1'b0; e_rv1[i] = 1'b0;
                e_wren[i] = 1'b0; e_busy[i] = 1'b0; e_cmd[i] = 1'b0; e_rst[i] = 1'b0;
            end
            e_rst[c+1] = 1'b1;
            m_prio  = 1'b0;
            free_at = c + 1;
        end else if (c >= free_at && (q_req[0] || q_req[1])) begin
            w = (q_req[0] && q_req[1]) ? m_prio : q_req[1];
            e_cmd[c+1]  = 1'b1;
            e_addr[c+1] = q_addr[w];
            e_data[c+1] = q_wdata[w];
            e_wren[c+1] = q_we[w];
            e_busy[c+1] = 1'b1;
            if (w) e_gnt1[c+1] = 1'b1; else e_gnt0[c+1] = 1'b1;
            if (q_we[w]) begin
                mem_m[q_addr[w]] = q_wdata[w];
                free_at = c + 2;
            end else begin
                e_busy[c+2] = 1'b1;
                if (w) e_rv1[c+3] = 1'b1; else e_rv0[c+3] = 1'b1;
                e_rd[c+3] = mem_m[q_addr[w]];
                free_at = c + 3;
            end
            m_prio = ~w;
        end
    endtask

    task automatic next_cycle();
        model_step(cyc);
        @(negedge clk);
        #1;
    endtask

    // compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            cc = cyc;
            if (e_rst[cc]) begin
                h_addr = 8'h00; h_rd0 = 32'h0; h_rd1 = 32'h0;
            end
            if (e_cmd[cc]) h_addr = e_addr[cc];
            if (e_rv0[cc]) h_rd0 = e_rd[cc];
            if (e_rv1[cc]) h_rd1 = e_rd[cc];
            chk("p0_gnt",    64'(bus.p0_gnt),    64'(e_gnt0[cc]));
            chk("p1_gnt",    64'(bus.p1_gnt),    64'(e_gnt1[cc]));
            chk("p0_rvalid", 64'(bus.p0_rvalid), 64'(e_rv0[cc]));
            chk("p1_rvalid", 64'(bus.p1_rvalid), 64'(e_rv1[cc]));
            chk("ram_wren",  64'(bus.ram_wren),  64'(e_wren[cc]));
            chk("busy",      64'(bus.busy),      64'(e_busy[cc]));
            chk("ram_addr",  64'(bus.ram_addr),  64'(h_addr));
            chk("p0_rdata",  64'(bus.p0_rdata),  64'(h_rd0));
            chk("p1_rdata",  64'(bus.p1_rdata),  64'(h_rd1));
            if (e_wren[cc]) chk("ram_data", 64'(bus.ram_data), 64'(e_data[cc]));
        end
    end

    // random requester behaviour for one cycle
    task automatic rand_drive(input bit greedy);
        logic g;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? bus.p0_gnt : bus.p1_gnt;
            if (q_req[k] && g) begin
                if (greedy || $urandom_range(0, 2) == 0)
                    set_port(k, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
                else
                    set_port(k, 1'b0, 1'b0, 8'h00, 32'h0);
            end else if (!q_req[k] && $urandom_range(0, 2) == 0) begin
                set_port(k, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            end
        end
    endtask

    int n_gnt, n_rep, last_port, first_port;
    bit greedy;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = $urandom;
            mem_m[i] = ram[i];
        end
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        #1;
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        chk("rst_busy",   64'(bus.busy),     64'd0);
        chk("rst_wren",   64'(bus.ram_wren), 64'd0);
        chk("rst_addr",   64'(bus.ram_addr), 64'd0);
        chk("rst_rdata0", 64'(bus.p0_rdata), 64'd0);
        rst = 1'b0;

        // single CPU write
        set_port(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        next_cycle();
        chk("wr_gnt",  64'(bus.p0_gnt),   64'd1);
        chk("wr_wren", 64'(bus.ram_wren), 64'd1);
        chk("wr_addr", 64'(bus.ram_addr), 64'h10);
        chk("wr_data", 64'(bus.ram_data), 64'hDEADBEEF);
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        chk("wr_end_wren", 64'(bus.ram_wren), 64'd0);
        chk("wr_end_busy", 64'(bus.busy),     64'd0);

        // CPU read-back
        set_port(0, 1'b1, 1'b0, 8'h10, 32'h0);
        next_cycle();
        chk("rd_gnt", 64'(bus.p0_gnt), 64'd1);
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        next_cycle();
        chk("rd_rvalid", 64'(bus.p0_rvalid), 64'd1);
        chk("rd_rdata",  64'(bus.p0_rdata),  64'hDEADBEEF);
        next_cycle();
        chk("rd_rvalid_end", 64'(bus.p0_rvalid), 64'd0);

        // simultaneous requests after reset, twice
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            set_port(0, 1'b1, 1'b0, 8'h01, 32'h0);
            set_port(1, 1'b1, 1'b1, 8'h02, 32'h5);
            next_cycle();
            chk("tie_p0_gnt", 64'(bus.p0_gnt), 64'd1);
            chk("tie_p1_wait", 64'(bus.p1_gnt), 64'd0);
            set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
            next_cycle();
            next_cycle();
            next_cycle();
            chk("tie_p1_gnt", 64'(bus.p1_gnt), 64'd1);
            set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
            next_cycle();
        end

        // both ports hold requests continuously for 8 accesses
        n_gnt = 0; n_rep = 0; last_port = -1; first_port = -1;
        set_port(0, 1'b1, 1'b1, 8'($urandom_range(0, 15)), $urandom);
        set_port(1, 1'b1, 1'b1, 8'($urandom_range(0, 15)), $urandom);
        for (int t = 0; t < 40 && n_gnt < 8; t++) begin
            next_cycle();
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && bus.p0_gnt) || (k == 1 && bus.p1_gnt)) begin
                    if (first_port < 0) first_port = k;
                    if (last_port == k) n_rep++;
                    last_port = k;
                    n_gnt++;
                    set_port(k, 1'b1, 1'b1, 8'($urandom_range(0, 15)), $urandom);
                end
            end
        end
        chk("alt_grants",  64'(n_gnt),      64'd8);
        chk("alt_repeats", 64'(n_rep),      64'd0);
        chk("alt_first",   64'(first_port), 64'd0);
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        next_cycle();
        next_cycle();

        // reset during the ISSUE cycle of a write
        set_port(0, 1'b1, 1'b1, 8'hFF, 32'hA5A5A5A5);
        next_cycle();
        chk("rsti_gnt", 64'(bus.p0_gnt), 64'd1);
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        chk("rsti_wren", 64'(bus.ram_wren), 64'd0);
        chk("rsti_busy", 64'(bus.busy),     64'd0);
        chk("rsti_addr", 64'(bus.ram_addr), 64'd0);
        chk("rsti_data", 64'(bus.ram_data), 64'd0);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            next_cycle();
            chk("rsti_no_rvalid", 64'(bus.p0_rvalid | bus.p1_rvalid), 64'd0);
        end

        // reset during RDWAIT of a read
        set_port(0, 1'b1, 1'b0, 8'h10, 32'h0);
        next_cycle();
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("rstr_rvalid", 64'(bus.p0_rvalid), 64'd0);
        chk("rstr_rdata",  64'(bus.p0_rdata),  64'd0);
        for (int t = 0; t < 3; t++) begin
            next_cycle();
            chk("rstr_no_rvalid", 64'(bus.p0_rvalid | bus.p1_rvalid), 64'd0);
        end

        // randomized traffic with sporadic resets
        greedy = 1'b0;
        for (int t = 0; t < 2500; t++) begin
            if (t % 200 == 0) greedy = 1'($urandom_range(0, 1));
            rand_drive(greedy);
            rst = ($urandom_range(0, 199) == 0);
            next_cycle();
        end
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int t = 0; t < 6; t++) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data RAM behind the memory/writeback stage. It shares the RAM between the CPU memory-stage port (port 0) and a loader/debug port (port 1) using round-robin arbitration. It drives the RAM address, data and write-enable from registers, and returns read data with a valid pulse that accounts for the RAM's one-cycle read latency. The CPU stalls on `p0_req & ~p0_gnt`.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- p0_req  in  1  port 0 (CPU) access request; held with command until p0_gnt
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 word address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  one-cycle pulse: port 0 command is on the RAM bus this cycle
- p0_rvalid  out  1  one-cycle pulse: p0_rdata holds port 0 read result
- p0_rdata  out  DATA_W  port 0 read data; holds until next p0 read
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- ram_addr  out  ADDR_W  registered RAM address
- ram_data  out  DATA_W  registered RAM write data
- ram_wren  out  1  registered RAM write enable
- ram_q  in  DATA_W  RAM read data; valid one cycle after the address is presented
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE, with no req: stay in IDLE. ram_wren=0; ram_addr and ram_data hold their values.
- IDLE, with any req:
  - Pick the winner, latch its command into ram_addr/ram_data/ram_wren, set its gnt, and go to ISSUE.
  - ram_wren = winner_we. ram_data is loaded even on reads; its value is don't-care.
- ISSUE:
  - The winner's gnt is high for exactly this cycle.
  - Write: go to IDLE. ram_wren clears at the next edge.
  - Read: go to RDWAIT. ram_wren is 0 throughout.
- RDWAIT:
  - Capture ram_q into the winner's rdata.
  - Pulse that port's rvalid in the following cycle, which is the IDLE cycle after RDWAIT.
  - Go to IDLE.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the port named by the priority bit `prio` wins.
  - After every grant, `prio` points to the non-granted port.
  - `prio` resets to 0 (CPU first).
- Requester contract: hold req, we, addr and wdata stable until gnt, then deassert req at or before the next edge. A req still high in the IDLE cycle after completion counts as a new request.
- A requester may assert req while its own read is pending. rvalid for the earlier read still arrives before any gnt for the new request.
- The losing port's req is ignored in ISSUE and RDWAIT. It is re-evaluated in the next IDLE cycle.

## Timing
- Request sampled in IDLE at cycle N. gnt and RAM command appear at N+1. The RAM samples at the end of N+1.
- Write: 2 cycles per access (IDLE, ISSUE). A back-to-back winner gets its next gnt no earlier than N+3.
- Read: ram_q is valid in N+2 (RDWAIT) and captured at the end of N+2. rvalid and rdata are presented in N+3, together with the next IDLE arbitration. Total 3 cycles per access.
- Worst-case wait for a port with req held continuously: one competing access (at most 3 cycles) plus its own access.
- Reset values: state=IDLE, prio=0, p0/p1_gnt=0, p0/p1_rvalid=0, p0/p1_rdata=0, ram_addr=0, ram_data=0, ram_wren=0, busy=0.
- Reset mid-operation:
  - ram_wren=0 from the edge at which rst is sampled high.
  - Any pending rvalid is discarded; it is not delivered after reset.
  - Requests present while rst is high are ignored.
- gnt and rvalid are never high for both ports in the same cycle.
- No combinational path from any req to any output.

## Test plan
- Single CPU write: p0_req=1, we=1, addr=0x10, wdata=0xDEADBEEF at N -> N+1: p0_gnt=1, ram_wren=1, ram_addr=0x10, ram_data=0xDEADBEEF. N+2: ram_wren=0, busy=0.
- CPU read-back of 0x10 -> p0_gnt at N+1, p0_rvalid=1 with p0_rdata=0xDEADBEEF at N+3, rvalid low at N+4.
- Simultaneous requests after reset: p0 reads 0x01, p1 writes 0x02=0x5 -> p0 granted first (prio=0), p1_gnt 3 cycles later. Repeat the same pair -> p0 granted first again, because prio returned to 0 after p1's grant.
- Both ports hold req continuously for 8 accesses -> grants alternate p0, p1, p0, ... with no port granted twice in a row.
- rst asserted in the ISSUE cycle of a write to 0xFF -> ram_wren=0 in the next cycle, all outputs at reset values, and no rvalid.
- rst asserted in RDWAIT -> no rvalid on either port, and p0_rdata remains 0.
